// File: rtl/ddr_phy_pkg.sv
// ddr_phy_pkg: shared DDR PHY types and defaults for the lane wrappers and calibration logic
package ddr_phy_pkg;
    localparam int DLY_W_DEF = 7;
    typedef logic [DLY_W_DEF-1:0] dly_t;
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_READ, S_WAIT, S_EVAL, S_NEXT, S_DONE, S_FAIL
    } rdcal_state_e;
endpackage

// File: rtl/ddr_dqs_rdcal_if.sv
// ddr_dqs_rdcal_if: init-sequencer request/status plus DQSBUFD strobe, delay and feedback for one lane
interface ddr_dqs_rdcal_if #(parameter int DLY_W = ddr_phy_pkg::DLY_W_DEF);
    logic             start;
    logic             read;
    logic             datavalid;
    logic             prmbdet;
    logic [DLY_W-1:0] dyndly;
    logic             busy;
    logic             done;
    logic             fail;
    modport master (input start, datavalid, prmbdet, output read, dyndly, busy, done, fail);
    modport slave  (output start, datavalid, prmbdet, input read, dyndly, busy, done, fail);
endinterface

// File: rtl/ddr_dqs_window.sv
// ddr_dqs_window: tracks the longest contiguous run of passing delay codes; the earliest run wins a tie.
// Outputs already include the code presented this cycle so the last code can be judged in the same cycle.
module ddr_dqs_window
    import ddr_phy_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             pass,
    input  logic [DLY_W-1:0] code,
    input  logic             valid,
    input  logic             clear,
    output logic [DLY_W-1:0] best_first,
    output logic [DLY_W-1:0] best_last,
    output logic             found
);
    logic [DLY_W-1:0] run_first_q, run_first_d, best_first_q, best_first_d;
    logic [DLY_W:0]   run_len_q, run_len_d, best_len_q, best_len_d;

    always_comb begin
        run_first_d  = run_first_q;
        run_len_d    = run_len_q;
        best_first_d = best_first_q;
        best_len_d   = best_len_q;
        if (clear) begin
            run_first_d  = '0;
            run_len_d    = '0;
            best_first_d = '0;
            best_len_d   = '0;
        end else if (valid) begin
            run_first_d = (run_len_q == '0) ? code : run_first_q;
            run_len_d   = pass ? run_len_q + 1'b1 : '0;
            // strictly longer only, so a later run of equal length never displaces the earlier one
            if (run_len_d > best_len_q) begin
                best_first_d = run_first_d;
                best_len_d   = run_len_d;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            run_first_q  <= '0;
            run_len_q    <= '0;
            best_first_q <= '0;
            best_len_q   <= '0;
        end else begin
            run_first_q  <= run_first_d;
            run_len_q    <= run_len_d;
            best_first_q <= best_first_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_first = best_first_d;
    assign best_last  = best_first_d + DLY_W'(best_len_d) - 1'b1;
    assign found      = |best_len_d;
endmodule

// File: rtl/ddr_dqs_rdcal.sv
// ddr_dqs_rdcal: read-gate calibration for one DQS lane; sweeps every DYNDELAY code with repeated
// reads and programs the centre of the longest passing window.
module ddr_dqs_rdcal
    import ddr_phy_pkg::*;
#(
    parameter int DLY_W    = DLY_W_DEF,
    parameter int SETTLE   = 8,
    parameter int READ_LEN = 2,
    parameter int SAMPLES  = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic            sclk,
    input  logic            rst,
    ddr_dqs_rdcal_if.master bus
);
    localparam int CMAX_A = TIMEOUT > SETTLE ? TIMEOUT : SETTLE;
    localparam int CW     = $clog2((CMAX_A > READ_LEN ? CMAX_A : READ_LEN) + 1);
    localparam int HW     = $clog2(SAMPLES + 1);

    rdcal_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    hits_q, hits_d, smp_q, smp_d;
    logic [DLY_W-1:0] dly_q, dly_d, best_first, best_last;
    logic [DLY_W:0]   mid_sum;
    logic             read_q, read_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic             dv_q, dv_d, pd_q, pd_d, win_clr, win_vld, win_found;

    ddr_dqs_window #(.DLY_W(DLY_W)) u_win (
        .sclk      (sclk),
        .rst       (rst),
        .pass      (hits_q == HW'(SAMPLES)),
        .code      (dly_q),
        .valid     (win_vld),
        .clear     (win_clr),
        .best_first(best_first),
        .best_last (best_last),
        .found     (win_found)
    );

    assign mid_sum = {1'b0, best_first} + {1'b0, best_last};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hits_d  = hits_q;
        smp_d   = smp_q;
        dly_d   = dly_q;
        read_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        fail_d  = fail_q;
        dv_d    = dv_q;
        pd_d    = pd_q;
        win_clr = 1'b0;
        win_vld = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: if (bus.start) begin
                state_d = S_SETTLE;
                cnt_d   = '0;
                hits_d  = '0;
                smp_d   = '0;
                dly_d   = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                fail_d  = 1'b0;
                win_clr = 1'b1;
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                    dv_d    = 1'b0;
                    pd_d    = 1'b0;
                end
            end
            S_READ: begin
                cnt_d  = cnt_q + 1'b1;
                read_d = cnt_q != CW'(READ_LEN - 1);
                if (cnt_q == CW'(READ_LEN - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // flags absorb this cycle's inputs, so datavalid on the final timeout cycle still counts
                cnt_d = cnt_q + 1'b1;
                dv_d  = dv_q | bus.datavalid;
                pd_d  = pd_q | bus.prmbdet;
                if (dv_q || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_EVAL;
                    cnt_d   = '0;
                end
            end
            S_EVAL: begin
                hits_d  = hits_q + HW'(dv_q & pd_q);
                smp_d   = smp_q + 1'b1;
                state_d = S_SETTLE;
                if (smp_q == HW'(SAMPLES - 1)) begin
                    state_d = S_NEXT;
                    smp_d   = '0;
                end
            end
            S_NEXT: begin
                win_vld = 1'b1;
                if (&dly_q) begin
                    busy_d  = 1'b0;
                    done_d  = win_found;
                    fail_d  = !win_found;
                    dly_d   = win_found ? mid_sum[DLY_W:1] : '0;
                    state_d = win_found ? S_DONE : S_FAIL;
                end else begin
                    dly_d   = dly_q + 1'b1;
                    hits_d  = '0;
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hits_q  <= '0;
            smp_q   <= '0;
            dly_q   <= '0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            dv_q    <= 1'b0;
            pd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
            smp_q   <= smp_d;
            dly_q   <= dly_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            dv_q    <= dv_d;
            pd_q    <= pd_d;
        end
    end

    assign bus.read   = read_q;
    assign bus.dyndly = dly_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.fail   = fail_q;
endmodule

// File: tb/tb_ddr_dqs_rdcal.sv
// tb_ddr_dqs_rdcal: lane model answering reads per delay code, window/timing reference model and
// per-cycle output checks for the read-gate calibrator.
module tb_ddr_dqs_rdcal;
    localparam int NC       = 128;
    localparam int P_SETTLE = 2;
    localparam int P_RD     = 2;
    localparam int P_SMP    = 4;
    localparam int P_TO     = 5;
    localparam int LIMIT    = 20000;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    ddr_dqs_rdcal_if #(.DLY_W(7)) bus ();

    ddr_dqs_rdcal #(
        .DLY_W(7), .SETTLE(P_SETTLE), .READ_LEN(P_RD), .SAMPLES(P_SMP), .TIMEOUT(P_TO)
    ) dut (
        .sclk(sclk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 sclk = ~sclk;

    int n_chk = 0, n_pass = 0;
    bit good[NC];
    bit pass_m[NC];
    int rd_cnt[NC];
    int miss_code = -1;
    bit noise = 0, rand_lat = 0, mon_en = 0;
    int model_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic clear_cfg();
        for (int c = 0; c < NC; c++) good[c] = 1'b0;
        miss_code = -1;
        noise     = 1'b0;
        rand_lat  = 1'b0;
    endtask

    task automatic add_win(input int a, input int b);
        for (int c = a; c <= b; c++) good[c] = 1'b1;
    endtask

    // enumerate maximal runs, keep the first one of greatest length
    function automatic void win_model(output bit ok, output int mid);
        int bf = 0, bl = 0, best = 0, e;
        for (int c = 0; c < NC; c++) begin
            if (pass_m[c] && (c == 0 || !pass_m[c-1])) begin
                e = c;
                while (e + 1 < NC && pass_m[e+1]) e++;
                if (e - c + 1 > best) begin
                    best = e - c + 1;
                    bf   = c;
                    bl   = e;
                end
            end
        end
        ok  = best > 0;
        mid = ok ? (bf + bl) / 2 : 0;
    endfunction

    // lane model: answers each read burst according to the code on dyndly when read falls
    int l_t, l_k, l_pk, l_code;
    bit l_act = 0, l_dv, l_pd, l_prev = 0, l_hit;
    initial begin
        bus.datavalid = 1'b0;
        bus.prmbdet   = 1'b0;
        forever begin
            @(negedge sclk);
            bus.datavalid = 1'b0;
            bus.prmbdet   = 1'b0;
            if (l_prev && !bus.read) begin
                l_code = int'(bus.dyndly);
                l_hit  = good[l_code] && !(l_code == miss_code && rd_cnt[l_code] == 2);
                rd_cnt[l_code]++;
                l_k    = rand_lat ? int'($urandom_range(P_TO - 1, 0)) : 3;
                l_pk   = (l_k > 0 && $urandom_range(1, 0) == 1) ? l_k - 1 : l_k;
                l_dv   = l_hit || noise;
                l_pd   = l_hit;
                l_act  = 1'b1;
                l_t    = 0;
                model_cyc += P_SETTLE + P_RD + (l_dv ? ((l_k + 2 < P_TO) ? l_k + 2 : P_TO) : P_TO) + 1;
            end
            if (l_act) begin
                if (l_t == l_pk) bus.prmbdet = l_pd;
                if (l_t == l_k) begin
                    bus.datavalid = l_dv;
                    l_act = 1'b0;
                end
                l_t++;
            end
            l_prev = bus.read;
        end
    end

    // per-cycle invariants on the registered outputs
    bit m_read = 0, m_busy = 0;
    int m_dly = 0, m_rlen = 0;
    initial forever begin
        @(negedge sclk);
        if (mon_en) begin
            if (bus.busy) chk("done/fail while busy", int'(bus.done | bus.fail), 0);
            if (bus.read && m_read) chk("dyndly moved during read", int'(bus.dyndly), m_dly);
            if (bus.busy && m_busy && int'(bus.dyndly) != m_dly) chk("dyndly step", int'(bus.dyndly), m_dly + 1);
            if (bus.read) m_rlen++;
            else if (m_read) begin
                chk("read width", m_rlen, P_RD);
                m_rlen = 0;
            end
        end else m_rlen = 0;
        m_read = bus.read;
        m_busy = bus.busy;
        m_dly  = int'(bus.dyndly);
    end

    task automatic run(input string nm, input int lit_ok, input int lit_dly, input int lit_cyc, input int poke);
        bit m_ok;
        int m_mid, cyc, first_rd, bad;
        for (int c = 0; c < NC; c++) begin
            pass_m[c] = good[c] && c != miss_code;
            rd_cnt[c] = 0;
        end
        win_model(m_ok, m_mid);
        if (lit_ok >= 0) begin
            chk({nm, " model ok"}, int'(m_ok), lit_ok);
            chk({nm, " model dyndly"}, m_mid, lit_dly);
        end
        model_cyc = 0;
        @(negedge sclk);
        bus.start = 1'b1;
        @(negedge sclk);
        bus.start = 1'b0;
        chk({nm, " busy rise"}, int'(bus.busy), 1);
        cyc = 0;
        first_rd = -1;
        while (!(bus.done || bus.fail) && cyc < LIMIT) begin
            if (bus.read && first_rd < 0) first_rd = cyc;
            @(negedge sclk);
            cyc++;
            bus.start = (cyc == poke);
        end
        bus.start = 1'b0;
        chk({nm, " finished in bound"}, int'(cyc < LIMIT), 1);
        chk({nm, " first read"}, first_rd, P_SETTLE);
        chk({nm, " done"}, int'(bus.done), int'(m_ok));
        chk({nm, " fail"}, int'(bus.fail), int'(!m_ok));
        chk({nm, " dyndly"}, int'(bus.dyndly), m_mid);
        chk({nm, " busy fall"}, int'(bus.busy), 0);
        chk({nm, " duration"}, cyc, model_cyc + NC);
        if (lit_cyc >= 0) chk({nm, " duration literal"}, cyc, lit_cyc);
        bad = 0;
        for (int c = 0; c < NC; c++) if (rd_cnt[c] != P_SMP) bad++;
        chk({nm, " codes with wrong read count"}, bad, 0);
        repeat (3) @(negedge sclk);
        chk({nm, " result held"}, int'({bus.done, bus.fail, bus.dyndly}), int'({m_ok, !m_ok, 7'(m_mid)}));
    endtask

    initial begin
        int j, nw, a, c;
        bus.start = 1'b0;
        repeat (3) @(negedge sclk);
        chk("reset read", int'(bus.read), 0);
        chk("reset dyndly", int'(bus.dyndly), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset fail", int'(bus.fail), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge sclk);

        clear_cfg(); add_win(40, 60);
        run("win40-60 with mid-sweep start", 1, 50, -1, 500);
        clear_cfg();
        run("no hits", 0, 0, 128 * (P_SMP * (P_SETTLE + P_RD + P_TO + 1) + 1), -1);
        clear_cfg(); add_win(10, 14); add_win(70, 90);
        run("two windows", 1, 80, -1, -1);
        clear_cfg(); add_win(20, 29); add_win(60, 69);
        run("tie", 1, 24, -1, -1);
        clear_cfg(); add_win(120, 127);
        run("open at end", 1, 123, -1, -1);
        clear_cfg(); add_win(0, 0);
        run("code 0 only", 1, 0, -1, -1);
        clear_cfg(); add_win(40, 60); miss_code = 45;
        run("hole at 45", 1, 53, -1, -1);
        clear_cfg(); noise = 1'b1;
        run("datavalid without prmbdet", 0, 0, -1, -1);

        for (int r = 0; r < 2; r++) begin
            clear_cfg();
            rand_lat = 1'b1;
            noise = 1'($urandom_range(1, 0));
            nw = int'($urandom_range(3, 1));
            for (int w = 0; w < nw; w++) begin
                a = int'($urandom_range(NC - 1, 0));
                c = a + int'($urandom_range(19, 0));
                add_win(a, c > NC - 1 ? NC - 1 : c);
            end
            c = int'($urandom_range(NC - 1, 0));
            if (good[c] && $urandom_range(1, 0) == 1) miss_code = c;
            run("random", -1, 0, -1, -1);
        end

        clear_cfg(); add_win(40, 60);
        @(negedge sclk);
        bus.start = 1'b1;
        @(negedge sclk);
        bus.start = 1'b0;
        j = 0;
        while (int'(bus.dyndly) != 30 && j < LIMIT) begin
            @(negedge sclk);
            j++;
        end
        chk("sweep reached 30", int'(bus.dyndly), 30);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge sclk);
        chk("rst read", int'(bus.read), 0);
        chk("rst dyndly", int'(bus.dyndly), 0);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst fail", int'(bus.fail), 0);
        rst = 1'b0;
        repeat (8) @(negedge sclk);
        mon_en = 1'b1;
        clear_cfg(); add_win(5, 9);
        run("after reset", 1, 7, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
